reset_sequencer: RTL and testbench

Parametrised reset and run-control sequencer placed between the top-level clock/reset pins and the MIPS core's per-unit resets (instruction memory, PC, register file, and any units added later). It holds every domain in reset for a programmable interval, releases the domains one at a time in index order with a programmable stagger, then counts run cycles and halts the core after a programmable limit. A synchronous soft-reset request restarts the whole sequence from any state. It replaces fixed, hand-timed reset releases, and gives benches and silicon a single deterministic bring-up and stop point.

---
 rtl/reset_sequencer.sv | 143 ++++++++++++++
 tb/tb_reset_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset and run-control sequencer: holds all core reset domains, releases them
// one by one in index order, then counts run cycles and halts at a limit.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 2,
    parameter int STAGGER     = 1,
    parameter int RUN_LIMIT   = 50,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sw_rst,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   clk_en,
    output logic                   ready,
    output logic                   halt,
    output logic [CNT_W-1:0]       run_cnt
);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_RUN,
        ST_HALT
    } state_t;

    localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [CNT_W-1:0] HOLD_C    = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STAGGER_C = CNT_W'(STAGGER);
    localparam logic [CNT_W-1:0] LIMIT_C   = CNT_W'(RUN_LIMIT);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
    logic                   clk_en_q, clk_en_d;
    logic                   ready_q, ready_d;
    logic                   halt_q, halt_d;
    logic [CNT_W-1:0]       run_cnt_q, run_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ASSERT;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            clk_en_q  <= 1'b0;
            ready_q   <= 1'b0;
            halt_q    <= 1'b0;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            clk_en_q  <= clk_en_d;
            ready_q   <= ready_d;
            halt_q    <= halt_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        clk_en_d  = clk_en_q;
        ready_d   = ready_q;
        halt_d    = halt_q;
        run_cnt_d = run_cnt_q;

        case (state_q)
            ST_ASSERT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == HOLD_C) begin
                    rst_out_d[0] = 1'b0;
                    cnt_d        = '0;
                    if (NUM_DOMAINS == 1) begin
                        state_d   = ST_RUN;
                        ready_d   = 1'b1;
                        clk_en_d  = 1'b1;
                        run_cnt_d = '0;
                    end else begin
                        state_d = ST_RELEASE;
                        idx_d   = IDX_W'(1);
                    end
                end
            end
            ST_RELEASE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == STAGGER_C) begin
                    cnt_d            = '0;
                    rst_out_d[idx_q] = 1'b0;
                    idx_d            = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d   = ST_RUN;
                        ready_d   = 1'b1;
                        clk_en_d  = 1'b1;
                        run_cnt_d = '0;
                    end
                end
            end
            ST_RUN: begin
                // Saturate rather than wrap so an unlimited run never looks restarted
                if (run_cnt_q != '1) begin
                    run_cnt_d = run_cnt_q + CNT_W'(1);
                end
                if ((RUN_LIMIT != 0) && (run_cnt_d == LIMIT_C)) begin
                    state_d  = ST_HALT;
                    halt_d   = 1'b1;
                    clk_en_d = 1'b0;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_ASSERT;
            end
        endcase

        // Soft reset overrides every transition and pins the hold counter at zero
        if (sw_rst) begin
            state_d   = ST_ASSERT;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            clk_en_d  = 1'b0;
            ready_d   = 1'b0;
            halt_d    = 1'b0;
            run_cnt_d = '0;
        end
    end

    assign rst_out = rst_out_q;
    assign clk_en  = clk_en_q;
    assign ready   = ready_q;
    assign halt    = halt_q;
    assign run_cnt = run_cnt_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: three parameter sets share rst_n/sw_rst and
// are compared each cycle against an edge-count reference model.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic sw_rst;

    logic [2:0]  rst_def, rst_wide_3;
    logic [4:0]  rst_wide;
    logic [2:0]  rst_sat;
    logic        ce_def, rd_def, ht_def;
    logic        ce_wide, rd_wide, ht_wide;
    logic        ce_sat, rd_sat, ht_sat;
    logic [15:0] rc_def, rc_wide;
    logic [3:0]  rc_sat;

    typedef struct packed {
        logic [7:0]  rst_out;
        logic        clk_en;
        logic        ready;
        logic        halt;
        logic [15:0] run_cnt;
    } exp_t;

    typedef struct {
        exp_t d;
        exp_t w;
        exp_t s;
    } trio_t;

    trio_t exp_q[$];
    trio_t mon_t;
    int    assert_count = 0;
    int    fail_count   = 0;
    int    n            = 0;
    bit    done         = 1'b0;

    always #5 clk = ~clk;

    reset_sequencer u_def (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .rst_out(rst_def),
        .clk_en(ce_def), .ready(rd_def), .halt(ht_def), .run_cnt(rc_def)
    );

    reset_sequencer #(.NUM_DOMAINS(5), .HOLD_CYCLES(3), .STAGGER(4)) u_wide (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .rst_out(rst_wide),
        .clk_en(ce_wide), .ready(rd_wide), .halt(ht_wide), .run_cnt(rc_wide)
    );

    reset_sequencer #(.RUN_LIMIT(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .sw_rst(sw_rst), .rst_out(rst_sat),
        .clk_en(ce_sat), .ready(rd_sat), .halt(ht_sat), .run_cnt(rc_sat)
    );

    assign rst_wide_3 = rst_wide[2:0];

    // Expected outputs after 'cur' edges since the last reset release
    function automatic exp_t model(input int cur, input int nd, input int hold,
                                   input int stag, input int lim, input int cw);
        exp_t e;
        int   r;
        int   run;
        int   maxc;
        e    = '0;
        r    = hold + (nd - 1) * stag;
        maxc = (1 << cw) - 1;
        for (int k = 0; k < nd; k++) begin
            e.rst_out[k] = (cur < hold + k * stag);
        end
        if (cur >= r) begin
            e.ready = 1'b1;
            run     = cur - r;
            if (lim != 0 && run >= lim) begin
                e.halt = 1'b1;
                run    = lim;
            end
            if (run > maxc) run = maxc;
            e.run_cnt = 16'(run);
            e.clk_en  = !e.halt;
        end
        return e;
    endfunction

    function automatic trio_t model_all(input int cur);
        trio_t t;
        t.d = model(cur, 3, 2, 1, 50, 16);
        t.w = model(cur, 5, 3, 4, 50, 16);
        t.s = model(cur, 3, 2, 1, 0, 4);
        return t;
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
        assert_count++;
        if (act !== req) begin
            fail_count++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic check_dut(input string tag, input exp_t e, input logic [15:0] ro,
                             input logic ce, input logic rd, input logic ht,
                             input logic [15:0] rc);
        check_output({tag, ".rst_out"}, ro, 16'(e.rst_out));
        check_output({tag, ".clk_en"}, 16'(ce), 16'(e.clk_en));
        check_output({tag, ".ready"}, 16'(rd), 16'(e.ready));
        check_output({tag, ".halt"}, 16'(ht), 16'(e.halt));
        check_output({tag, ".run_cnt"}, rc, e.run_cnt);
    endtask

    task automatic check_all(input trio_t t);
        check_dut("def", t.d, 16'(rst_def), ce_def, rd_def, ht_def, rc_def);
        check_dut("wide", t.w, 16'(rst_wide), ce_wide, rd_wide, ht_wide, rc_wide);
        check_dut("sat", t.s, 16'(rst_sat), ce_sat, rd_sat, ht_sat, 16'(rc_sat));
    endtask

    // Monitor: one expected entry per clock edge, compared away from the edge
    always @(negedge clk) begin
        if (!done) begin
            if (exp_q.size() == 0) begin
                assert_count++;
                fail_count++;
                $display("[TB] FAIL scoreboard at %0t: got empty queue, expected an entry", $time);
            end else begin
                mon_t = exp_q.pop_front();
                check_all(mon_t);
            end
        end
    end

    // Drive inputs for the next edge and queue what that edge must produce
    task automatic apply_stimulus(input logic rn, input logic sw);
        logic was_high;
        was_high = (rst_n === 1'b1);
        rst_n    = rn;
        sw_rst   = sw;
        if (was_high && !rn) begin
            #1;
            check_all(model_all(0));
        end
        if (!rn || sw) n = 0;
        else if (n < 1000000) n++;
        exp_q.push_back(model_all(n));
        @(negedge clk);
        #1;
    endtask

    initial begin
        int r;
        rst_n  = 1'b0;
        sw_rst = 1'b0;
        $display("[TB] reset_sequencer scoreboard run starting");

        repeat (2) apply_stimulus(1'b0, 1'b0);
        repeat (19) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1);
        repeat (60) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b1);
        repeat (30) apply_stimulus(1'b1, 1'b0);
        repeat (10) apply_stimulus(1'b1, 1'b1);
        repeat (30) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        repeat (2) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        repeat (80) apply_stimulus(1'b1, 1'b0);

        repeat (3000) begin
            r = int'($urandom_range(0, 199));
            if (r < 3) begin
                apply_stimulus(1'b1, 1'b1);
            end else if (r < 5) begin
                repeat ($urandom_range(1, 3)) apply_stimulus(1'b0, 1'(($urandom_range(0, 1))));
            end else begin
                apply_stimulus(1'b1, 1'b0);
            end
        end

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
